// File: rtl/tt_um_shifter_left_seq.sv
// tt_um_shifter_left_seq: iterative left shifter/rotator for a Tiny Tapeout tile.
// Shifts the 8-bit operand left by one bit per clock. Amount, start and
// rotate select come in on uio_in. Busy and done go out on uio_out[7:6].
// Optional feature macro: SHIFTER_ROTATE_EN (rotate-left via uio_in[4]).
module tt_um_shifter_left_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned AMT_W  = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [AMT_W-1:0]  count_q, count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rot_q;
    logic              fill;

    logic              start;
    logic [AMT_W-1:0]  amt;

    assign start = uio_in[3];
    assign amt   = uio_in[AMT_W-1:0];

`ifdef SHIFTER_ROTATE_EN
    logic rot_d;

    // Rotate select is captured only at the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rot_q <= 1'b0;
        else        rot_q <= rot_d;
    end

    // Ignored tile inputs, reduced so they are visibly consumed
    logic unused_ok;
    assign unused_ok = &{ena, uio_in[7:5], 1'b0};
`else
    assign rot_q = 1'b0;

    // Ignored tile inputs (rotate select included in this build)
    logic unused_ok;
    assign unused_ok = &{ena, uio_in[7:4], 1'b0};
`endif

    assign fill = rot_q ? result_q[DATA_W-1] : 1'b0;

    // State, result, count and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: accept in IDLE, one bit per edge in SHIFT, hold in WAIT_REL
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        count_d  = count_q;
        busy_d   = busy_q;
        done_d   = done_q;
`ifdef SHIFTER_ROTATE_EN
        rot_d    = rot_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    result_d = ui_in;
                    count_d  = amt;
`ifdef SHIFTER_ROTATE_EN
                    rot_d    = uio_in[4];
`endif
                    if (amt == '0) begin
                        state_d = WAIT_REL;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = SHIFT;
                        done_d  = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                result_d = {result_q[DATA_W-2:0], fill};
                count_d  = count_q - 1'b1;
                if (count_q == AMT_W'(1)) begin
                    state_d = WAIT_REL;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            WAIT_REL: begin
                if (!start) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign uo_out  = result_q;
    assign uio_out = {busy_q, done_q, 6'b00_0000};
    assign uio_oe  = 8'b1100_0000;

endmodule

// File: tb/tb_tt_um_shifter_left_seq.sv
// Directed testbench for tt_um_shifter_left_seq.
module tb_tt_um_shifter_left_seq;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_assert;
    int n_fail;

    localparam logic [7:0] ST_IDLE0 = 8'h00;
    localparam logic [7:0] ST_BUSY  = 8'h80;
    localparam logic [7:0] ST_DONE  = 8'h40;

`ifdef SHIFTER_ROTATE_EN
    localparam logic [7:0] ROT_EXP = 8'h0C;
`else
    localparam logic [7:0] ROT_EXP = 8'h08;
`endif

    tt_um_shifter_left_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample on the falling edge
    task automatic step();
        @(negedge clk);
    endtask

    // uio_in = {3'b0, rot, start, amt}
    function automatic logic [7:0] ctl(input logic rot, input logic st, input logic [2:0] a);
        return {3'b000, rot, st, a};
    endfunction

    initial begin
        n_assert = 0;
        n_fail   = 0;
        ena      = 1'b1;
        rst_n    = 1'b0;
        ui_in    = 8'h00;
        uio_in   = 8'h00;

        // Reset state
        #3;
        check("rst_uo", uo_out, 8'h00);
        check("rst_uio", uio_out, ST_IDLE0);
        check("rst_oe", uio_oe, 8'hC0);
        step();
        rst_n = 1'b1;
        step();
        check("idle_uio", uio_out, ST_IDLE0);

        // 0x81 << 3, one-cycle start pulse
        ui_in  = 8'h81;
        uio_in = ctl(1'b0, 1'b1, 3'd3);
        step();
        check("t1_acc_uio", uio_out, ST_BUSY);
        check("t1_acc_uo", uo_out, 8'h81);
        uio_in = ctl(1'b0, 1'b0, 3'd3);
        ui_in  = 8'hFF;
        step();
        check("t1_e1_uio", uio_out, ST_BUSY);
        check("t1_e1_uo", uo_out, 8'h02);
        step();
        check("t1_e2_uio", uio_out, ST_BUSY);
        step();
        check("t1_done_uio", uio_out, ST_DONE);
        check("t1_done_uo", uo_out, 8'h08);
        step();
        step();
        check("t1_hold_uio", uio_out, ST_DONE);
        check("t1_hold_uo", uo_out, 8'h08);

        // Amount 0, start held 5 cycles: done after 1 edge, no retrigger
        ui_in  = 8'hA5;
        uio_in = ctl(1'b0, 1'b1, 3'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_uio", uio_out, ST_DONE);
            check("t2_uo", uo_out, 8'hA5);
            ui_in = 8'h3C;
        end
        uio_in = ctl(1'b0, 1'b0, 3'd0);
        step();
        check("t2_rel_uo", uo_out, 8'hA5);

        // 0x81 << 7 logical
        ui_in  = 8'h81;
        uio_in = ctl(1'b0, 1'b1, 3'd7);
        step();
        check("t3_acc_uio", uio_out, ST_BUSY);
        uio_in = ctl(1'b0, 1'b0, 3'd7);
        for (int i = 0; i < 6; i++) begin
            step();
            check("t3_busy_uio", uio_out, ST_BUSY);
        end
        step();
        check("t3_done_uio", uio_out, ST_DONE);
        check("t3_done_uo", uo_out, 8'h80);
        step();

        // Rotate select with 0x81 amt 3 (rotate only in the feature build)
        ui_in  = 8'h81;
        uio_in = ctl(1'b1, 1'b1, 3'd3);
        step();
        uio_in = ctl(1'b1, 1'b0, 3'd3);
        step();
        step();
        check("t4_busy_uio", uio_out, ST_BUSY);
        step();
        check("t4_done_uio", uio_out, ST_DONE);
        check("t4_done_uo", uo_out, ROT_EXP);
        step();

        // Inputs changed during SHIFT are ignored: 0x0F << 4
        ui_in  = 8'h0F;
        uio_in = ctl(1'b0, 1'b1, 3'd4);
        step();
        check("t5_acc_uio", uio_out, ST_BUSY);
        ui_in  = 8'h00;
        uio_in = ctl(1'b1, 1'b1, 3'd1);
        step();
        check("t5_e1_uo", uo_out, 8'h1E);
        check("t5_e1_uio", uio_out, ST_BUSY);
        step();
        check("t5_e2_uio", uio_out, ST_BUSY);
        step();
        check("t5_e3_uio", uio_out, ST_BUSY);
        step();
        check("t5_done_uio", uio_out, ST_DONE);
        check("t5_done_uo", uo_out, 8'hF0);
        step();
        check("t5_held_uio", uio_out, ST_DONE);
        check("t5_held_uo", uo_out, 8'hF0);

        // Back-to-back: drop start one cycle, then 0x01 << 2
        uio_in = ctl(1'b0, 1'b0, 3'd1);
        step();
        check("t6_idle_uio", uio_out, ST_DONE);
        ui_in  = 8'h01;
        uio_in = ctl(1'b0, 1'b1, 3'd2);
        step();
        check("t6_acc_uio", uio_out, ST_BUSY);
        uio_in = ctl(1'b0, 1'b0, 3'd2);
        step();
        check("t6_e1_uio", uio_out, ST_BUSY);
        step();
        check("t6_done_uio", uio_out, ST_DONE);
        check("t6_done_uo", uo_out, 8'h04);
        step();

        // Asynchronous reset mid-shift of 0xFF amt 5
        ui_in  = 8'hFF;
        uio_in = ctl(1'b0, 1'b1, 3'd5);
        step();
        uio_in = ctl(1'b0, 1'b0, 3'd5);
        step();
        step();
        check("t7_mid_uio", uio_out, ST_BUSY);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_uo", uo_out, 8'h00);
        check("t7_rst_uio", uio_out, ST_IDLE0);
        check("t7_rst_oe", uio_oe, 8'hC0);
        step();
        rst_n = 1'b1;
        step();
        check("t7_post_uo", uo_out, 8'h00);
        check("t7_post_uio", uio_out, ST_IDLE0);
        ui_in  = 8'h03;
        uio_in = ctl(1'b0, 1'b1, 3'd1);
        step();
        check("t7_acc_uio", uio_out, ST_BUSY);
        uio_in = ctl(1'b0, 1'b0, 3'd1);
        step();
        check("t7_done_uio", uio_out, ST_DONE);
        check("t7_done_uo", uo_out, 8'h06);
        check("t7_done_oe", uio_oe, 8'hC0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
